layer_sequencer: RTL and testbench

// - Top-level layer scheduler. Walks a programmed layer list and launches conv, pool or dense engine controllers one at a time.
// - Grants the shared PE array and buffer m1 control ports to exactly one engine via eng_sel.
// - Sets the ping-pong buffer direction per layer; sits between regfile/host and the engine controllers.

---
 rtl/layer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer scheduler: walks a programmed list of conv/pool/dense layers and launches one engine at a time.
// Optional engine-wait watchdog, enabled by defining LAYER_SEQ_WDOG_EN.
`timescale 1ns/1ps
module layer_sequencer #(
  parameter int N_LAYERS = 8,   // must be >= 2 so cur_layer has at least one bit
  parameter int WDOG_W   = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          abort,
  input  logic [$clog2(N_LAYERS+1)-1:0] n_layers,
  input  logic [2*N_LAYERS-1:0]         layer_types,
  input  logic                          conv_done,
  input  logic                          pool_done,
  input  logic                          dense_done,
  output logic                          conv_start,
  output logic                          pool_start,
  output logic                          dense_start,
  output logic [1:0]                    eng_sel,
  output logic [1:0]                    aybz_azby,
  output logic [$clog2(N_LAYERS)-1:0]   cur_layer,
  output logic                          busy,
  output logic                          seq_done,
  output logic                          err
);
  localparam int CNT_W = $clog2(N_LAYERS+1);
  localparam int IDX_W = $clog2(N_LAYERS);
  localparam logic [1:0] DIR_1TO2 = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_SWAP, S_FINISH} state_t;
  typedef enum logic [1:0] {ENG_CONV = 2'd0, ENG_POOL = 2'd1, ENG_DENSE = 2'd2, ENG_NONE = 2'd3} eng_t;

  state_t           state;
  eng_t             owner;
  eng_t             launch_eng;
  logic [1:0]       type_of [N_LAYERS];
  logic [CNT_W-1:0] n_eff;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] launch_idx;
  logic             last_layer;
  logic             sel_done;
  logic             stray_done;
`ifdef LAYER_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic [WDOG_W-1:0] wdog_nxt;
  assign wdog_nxt = wdog_cnt + WDOG_W'(1);
`endif

  // One-hot start vector {dense, pool, conv}; a reserved type launches nothing.
  function automatic logic [2:0] start_vec(input eng_t e);
    start_vec = 3'b000;
    if (e != ENG_NONE) start_vec[e] = 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_LAYERS; i++) type_of[i] = layer_types[2*i +: 2];
  end

  assign n_eff      = (n_layers > CNT_W'(N_LAYERS)) ? CNT_W'(N_LAYERS) : n_layers;
  assign next_idx   = cur_layer + IDX_W'(1);
  assign last_layer = (CNT_W'(cur_layer) + CNT_W'(1)) == n_eff;
  // The layer about to launch: layer 0 when leaving IDLE, the next layer when leaving SWAP.
  assign launch_idx = (state == S_IDLE) ? '0 : next_idx;
  assign launch_eng = eng_t'(type_of[launch_idx]);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    sel_done   = 1'b0;
    stray_done = 1'b0;
    case (owner)
      ENG_CONV:  begin sel_done = conv_done;  stray_done = pool_done | dense_done; end
      ENG_POOL:  begin sel_done = pool_done;  stray_done = conv_done | dense_done; end
      ENG_DENSE: begin sel_done = dense_done; stray_done = conv_done | pool_done;  end
      default:   ;
    endcase
  end

  assign eng_sel  = owner;
  assign busy     = (state != S_IDLE);
  assign seq_done = (state == S_FINISH);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= ENG_NONE;
      conv_start  <= 1'b0;
      pool_start  <= 1'b0;
      dense_start <= 1'b0;
      aybz_azby   <= DIR_1TO2;
      cur_layer   <= '0;
      err         <= 1'b0;
`ifdef LAYER_SEQ_WDOG_EN
      wdog_cnt    <= '0;
`endif
    end else begin
      {dense_start, pool_start, conv_start} <= 3'b000;
      if (abort) begin
        state <= S_IDLE;
        owner <= ENG_NONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              err <= 1'b0;
              if (n_eff != '0) begin
                state     <= S_LAUNCH;
                cur_layer <= '0;
                aybz_azby <= DIR_1TO2;
                owner     <= launch_eng;
                {dense_start, pool_start, conv_start} <= start_vec(launch_eng);
              end else begin
                state <= S_FINISH;
              end
            end
          end
          S_LAUNCH: begin
            if (owner == ENG_NONE) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_WAIT;
`ifdef LAYER_SEQ_WDOG_EN
              wdog_cnt <= '0;
`endif
            end
          end
          S_WAIT: begin
            if (stray_done) err <= 1'b1;
            if (sel_done) begin
              state <= S_SWAP;
              owner <= ENG_NONE;
            end
`ifdef LAYER_SEQ_WDOG_EN
            // Timeout fires on the edge where the count reaches all-ones.
            else if (wdog_nxt == '1) begin
              err   <= 1'b1;
              owner <= ENG_NONE;
              state <= S_IDLE;
            end else begin
              wdog_cnt <= wdog_nxt;
            end
`endif
          end
          S_SWAP: begin
            aybz_azby <= ~aybz_azby;
            if (last_layer) begin
              state <= S_FINISH;
            end else begin
              state     <= S_LAUNCH;
              cur_layer <= next_idx;
              owner     <= launch_eng;
              {dense_start, pool_start, conv_start} <= start_vec(launch_eng);
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed scenarios plus randomized traffic against a
// phase-level reference model of the scheduler, compared on every cycle.
`timescale 1ns/1ps
module tb_layer_sequencer;
  localparam int N  = 8;
  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);
  localparam int WDOG_WAIT_CYCLES = 15;  // WDOG_W = 4: all-ones count

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] n_layers = '0;
  logic [1:0]    ty_cfg [N];
  logic [2*N-1:0] layer_types;
  logic [2:0]    a_done = '0;
  logic [2:0]    d_done = '0;
  logic          a_en = 1'b0;
  logic          conv_done, pool_done, dense_done;
  logic          conv_start, pool_start, dense_start;
  logic [1:0]    eng_sel, aybz_azby;
  logic [IW-1:0] cur_layer;
  logic          busy, seq_done, err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign conv_done  = a_done[0] | d_done[0];
  assign pool_done  = a_done[1] | d_done[1];
  assign dense_done = a_done[2] | d_done[2];

  always_comb begin
    for (int i = 0; i < N; i++) layer_types[2*i +: 2] = ty_cfg[i];
  end

  layer_sequencer #(.N_LAYERS(N), .WDOG_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort),
    .n_layers(n_layers), .layer_types(layer_types),
    .conv_done(conv_done), .pool_done(pool_done), .dense_done(dense_done),
    .conv_start(conv_start), .pool_start(pool_start), .dense_start(dense_start),
    .eng_sel(eng_sel), .aybz_azby(aybz_azby), .cur_layer(cur_layer),
    .busy(busy), .seq_done(seq_done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the scheduler is doing, in terms of layer progress.
  typedef enum {M_IDLE, M_LAUNCH, M_RUN, M_GAP, M_DONE} phase_t;
  phase_t     m_phase = M_IDLE;
  int         m_layer = 0;
  int         m_nl = 0;
  int         m_waited = 0;
  logic [1:0] m_dir = 2'b01;
  logic       m_err = 1'b0;
  logic [1:0] m_ty [N];

  always @(posedge clk or posedge rst) begin
    logic [2:0] dones;
    dones = {dense_done, pool_done, conv_done};
    if (rst) begin
      m_phase = M_IDLE; m_layer = 0; m_dir = 2'b01; m_err = 1'b0; m_nl = 0; m_waited = 0;
      for (int i = 0; i < N; i++) m_ty[i] = 2'd0;
    end else if (abort) begin
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: if (run) begin
          m_err = 1'b0;
          m_nl  = (int'(n_layers) > N) ? N : int'(n_layers);
          for (int i = 0; i < N; i++) m_ty[i] = ty_cfg[i];
          if (m_nl == 0) m_phase = M_DONE;
          else begin m_phase = M_LAUNCH; m_layer = 0; m_dir = 2'b01; end
        end
        M_LAUNCH: begin
          if (m_ty[m_layer] == 2'd3) begin m_err = 1'b1; m_phase = M_IDLE; end
          else begin m_phase = M_RUN; m_waited = 0; end
        end
        M_RUN: begin
          m_waited++;
          if ((dones & ~(3'b001 << m_ty[m_layer])) != 3'b000) m_err = 1'b1;
          if (dones[m_ty[m_layer]]) m_phase = M_GAP;
`ifdef LAYER_SEQ_WDOG_EN
          else if (m_waited == WDOG_WAIT_CYCLES) begin m_err = 1'b1; m_phase = M_IDLE; end
`endif
        end
        M_GAP: begin
          m_dir = ~m_dir;
          if (m_layer + 1 == m_nl) m_phase = M_DONE;
          else begin m_layer++; m_phase = M_LAUNCH; end
        end
        M_DONE: m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Per-cycle compare plus event log used by the directed scenarios.
  typedef struct {logic [1:0] ty; logic [1:0] dir; logic [IW-1:0] idx;} start_rec_t;
  start_rec_t start_log [$];
  int seq_done_cnt = 0;
  int busy_cnt = 0;

  always @(posedge clk) begin
    logic [1:0] et;
    logic       active;
    #1;
    if (!rst) begin
      et     = m_ty[m_layer];
      active = (m_phase == M_LAUNCH) || (m_phase == M_RUN);
      check("conv_start",  conv_start,  (m_phase == M_LAUNCH) && (et == 2'd0));
      check("pool_start",  pool_start,  (m_phase == M_LAUNCH) && (et == 2'd1));
      check("dense_start", dense_start, (m_phase == M_LAUNCH) && (et == 2'd2));
      check("eng_sel",     eng_sel,     active ? et : 2'd3);
      check("aybz_azby",   aybz_azby,   m_dir);
      if (active) check("cur_layer", cur_layer, m_layer);
      check("busy",        busy,        m_phase != M_IDLE);
      check("seq_done",    seq_done,    m_phase == M_DONE);
      check("err",         err,         m_err);
      if (conv_start | pool_start | dense_start)
        start_log.push_back('{ty: (pool_start ? 2'd1 : dense_start ? 2'd2 : 2'd0), dir: aybz_azby, idx: cur_layer});
      if (seq_done) seq_done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // Random engine responder: done some cycles after each start, plus occasional stray dones.
  int       a_cnt = 0;
  int       a_eng = 0;
  always @(negedge clk) begin
    a_done = 3'b000;
    if (a_en) begin
      if (a_cnt > 0) begin
        a_cnt--;
        if (a_cnt == 0) a_done[a_eng] = 1'b1;
      end
      if (conv_start | pool_start | dense_start) begin
        a_eng = pool_start ? 1 : dense_start ? 2 : 0;
        a_cnt = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 49) == 0) a_done[$urandom_range(0, 2)] = 1'b1;
    end
  end

  task automatic cfg(input int n, input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] t2);
    n_layers = CW'(n);
    for (int i = 0; i < N; i++) ty_cfg[i] = 2'd0;
    ty_cfg[0] = t0; ty_cfg[1] = t1; ty_cfg[2] = t2;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_start(output int ty, output bit ok);
    ok = 1'b0; ty = 3;
    for (int i = 0; i < 60; i++) begin
      if (conv_start | pool_start | dense_start) begin
        ok = 1'b1;
        ty = pool_start ? 1 : dense_start ? 2 : 0;
        break;
      end
      @(negedge clk);
    end
    check("start_seen", ok, 1'b1);
  endtask

  task automatic serve(input int delay);
    int ty;
    bit ok;
    wait_start(ty, ok);
    if (ok) begin
      repeat (delay) @(negedge clk);
      d_done[ty] = 1'b1;
      @(negedge clk);
      d_done = 3'b000;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check("idle_reached", !busy, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int s0, d0, b0;
    for (int i = 0; i < N; i++) ty_cfg[i] = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_eng_sel", eng_sel, 2'd3);
    check("rst_aybz", aybz_azby, 2'b01);
    check("rst_cur_layer", cur_layer, '0);
    check("rst_err", err, 1'b0);
    check("rst_starts", {conv_start, pool_start, dense_start, seq_done}, 4'b0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three layers conv, pool, dense with done 10 cycles after each start.
    cfg(3, 2'd0, 2'd1, 2'd2);
    s0 = start_log.size(); d0 = seq_done_cnt;
    pulse_run();
    for (int k = 0; k < 3; k++) serve(10);
    wait_idle(50);
    check("A_starts", start_log.size() - s0, 3);
    if (start_log.size() - s0 == 3) begin
      check("A_order", {start_log[s0].ty, start_log[s0+1].ty, start_log[s0+2].ty}, 6'b00_01_10);
      check("A_dir", {start_log[s0].dir, start_log[s0+1].dir, start_log[s0+2].dir}, 6'b01_10_01);
      check("A_idx", {start_log[s0].idx, start_log[s0+1].idx, start_log[s0+2].idx}, {3'd0, 3'd1, 3'd2});
    end
    check("A_seq_done", seq_done_cnt - d0, 1);
    check("A_err", err, 1'b0);

    // Zero layers: seq_done in the cycle after run is sampled, busy for that one cycle only.
    cfg(0, 2'd0, 2'd0, 2'd0);
    s0 = start_log.size(); b0 = busy_cnt;
    pulse_run();
    check("B_seq_done", seq_done, 1'b1);
    @(negedge clk);
    check("B_seq_done_off", seq_done, 1'b0);
    check("B_busy_cycles", busy_cnt - b0, 1);
    check("B_no_start", start_log.size() - s0, 0);

    // One pool layer, stray conv_done while waiting.
    cfg(1, 2'd1, 2'd0, 2'd0);
    pulse_run();
    @(negedge clk);
    d_done[0] = 1'b1;
    @(negedge clk);
    d_done = 3'b000;
    check("C_err_set", err, 1'b1);
    check("C_still_wait", {busy, eng_sel}, {1'b1, 2'd1});
    d_done[1] = 1'b1;
    @(negedge clk);
    d_done = 3'b000;
    @(negedge clk);
    check("C_seq_done", seq_done, 1'b1);
    @(negedge clk);
    check("C_err_sticky", {busy, err}, 2'b01);

    // Layer 1 reserved: layer 0 runs, then err and back to IDLE without seq_done.
    cfg(2, 2'd0, 2'd3, 2'd0);
    s0 = start_log.size(); d0 = seq_done_cnt;
    pulse_run();
    check("D_err_cleared", err, 1'b0);
    serve(3);
    wait_idle(20);
    check("D_starts", start_log.size() - s0, 1);
    check("D_err", err, 1'b1);
    check("D_no_seq_done", seq_done_cnt - d0, 0);

    // Abort three cycles into WAIT of layer 1, then restart from layer 0.
    begin
      int ty;
      bit ok;
      cfg(3, 2'd0, 2'd1, 2'd2);
      pulse_run();
      serve(4);
      wait_start(ty, ok);
      check("E_layer1_type", ty, 1);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("E_abort_idle", {busy, eng_sel, seq_done}, {1'b0, 2'd3, 1'b0});
      check("E_abort_err", err, 1'b0);
      pulse_run();
      check("E_restart", {conv_start, cur_layer, aybz_azby}, {1'b1, 3'd0, 2'b01});
      for (int k = 0; k < 3; k++) serve(2);
      wait_idle(30);
    end

    // Engine never answers.
    cfg(1, 2'd0, 2'd0, 2'd0);
    d0 = seq_done_cnt;
    pulse_run();
`ifdef LAYER_SEQ_WDOG_EN
    repeat (WDOG_WAIT_CYCLES) @(negedge clk);
    check("F_wdog_before", busy, 1'b1);
    @(negedge clk);
    check("F_wdog_fired", {busy, err, eng_sel}, {1'b0, 1'b1, 2'd3});
    check("F_wdog_no_done", seq_done_cnt - d0, 0);
`else
    repeat (40) @(negedge clk);
    check("F_still_wait", {busy, eng_sel, err}, {1'b1, 2'd0, 1'b0});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("F_abort_idle", busy, 1'b0);
`endif

    // Randomized traffic; configuration only changes while the scheduler is idle.
    a_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      run = 1'b0;
      abort = 1'b0;
      if (m_phase == M_IDLE && $urandom_range(0, 3) == 0) begin
        n_layers = CW'($urandom_range(0, N + 2));
        for (int i = 0; i < N; i++) begin
          int r;
          r = $urandom_range(0, 19);
          ty_cfg[i] = (r < 2) ? 2'd3 : 2'(r % 3);
        end
      end
      if ($urandom_range(0, 4) == 0) run = 1'b1;
      if ($urandom_range(0, 99) == 0) abort = 1'b1;
      @(negedge clk);
    end
    run = 1'b0;
    a_en = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("end_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
